// File: rtl/ddr2pe_dispatch.sv
// DDR-to-PE instruction dispatcher: queued DDR read instructions issue
// against a per-target / per-channel busy scoreboard.
module ddr2pe_dispatch #(
  parameter int PE_NUM  = 32,
  parameter int INS_W   = 64,
  parameter int TGT_NUM = 4,
  parameter int DDR_CH  = 2,
  parameter int ADDR_W  = 32,
  parameter int BURST_W = 8,
  parameter int Q_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [3:0]                 layer_type,
  input  logic [7:0]                 image_width,
  input  logic [3:0]                 in_ch_seg,
  input  logic                       ins_valid,
  output logic                       ins_ready,
  input  logic [INS_W-1:0]           ins,
  output logic [TGT_NUM-1:0]         tgt_start,
  input  logic [TGT_NUM-1:0]         tgt_done,
  output logic [3:0]                 conf_mode,
  output logic [7:0]                 conf_size,
  output logic [3:0]                 conf_row_num,
  output logic [3:0]                 conf_pix_num,
  output logic                       conf_depool,
  output logic [PE_NUM-1:0]          conf_mask,
  output logic [DDR_CH-1:0]          ddr_start,
  input  logic [DDR_CH-1:0]          ddr_done,
  output logic [DDR_CH*ADDR_W-1:0]   ddr_st_addr,
  output logic [DDR_CH*BURST_W-1:0]  ddr_burst,
  output logic [DDR_CH*ADDR_W-1:0]   ddr_step,
  output logic [DDR_CH*BURST_W-1:0]  ddr_burst_num,
  output logic [DDR_CH*2-1:0]        ddr_src_sel,
  output logic                       idle,
  output logic                       err_ch
);

  localparam int AW = $clog2(Q_DEPTH);
  localparam logic [AW:0] Q_FULL = (AW+1)'(Q_DEPTH);
  localparam logic [2:0] CH_LIM = 3'(DDR_CH);
  localparam logic [PE_NUM-1:0] PE_ONE = PE_NUM'(1);
  localparam logic [PE_NUM-1:0] PE_NIB = PE_NUM'(4'hF);

  typedef struct packed {
    logic [3:0]  tgt;
    logic [1:0]  ch;
    logic        str;
    logic [4:0]  buf_id;
    logic        dp;
    logic [3:0]  row;
    logic [3:0]  pix;
    logic [7:0]  size;
    logic [31:0] addr;
  } ins_t;

  ins_t             mem_q [Q_DEPTH];
  logic [AW-1:0]    wp_q, rp_q;
  logic [AW:0]      cnt_q, cnt_d;
  logic [TGT_NUM-1:0] busy_tgt_q, busy_tgt_d;
  logic [DDR_CH-1:0]  busy_ch_q, busy_ch_d;

  logic [TGT_NUM-1:0] tgt_start_q;
  logic [DDR_CH-1:0]  ddr_start_q;
  logic [3:0]         mode_q;
  logic [7:0]         size_q;
  logic [3:0]         row_q, pix_q;
  logic               dp_q;
  logic [PE_NUM-1:0]  mask_q;
  logic               idle_q, err_q;

  logic [ADDR_W-1:0]  st_addr_q [DDR_CH];
  logic [BURST_W-1:0] burst_q   [DDR_CH];
  logic [ADDR_W-1:0]  step_q    [DDR_CH];
  logic [BURST_W-1:0] bnum_q    [DDR_CH];
  logic [1:0]         src_q     [DDR_CH];

  ins_t ins_f, hd;
  logic wr_en, empty, full;
  logic [TGT_NUM-1:0] hd_tgt;
  logic [DDR_CH-1:0]  ch_oh;
  logic hd_nop, ch_ok, ch_busy, tgt_free;
  logic pop, issue, bad;
  logic [PE_NUM-1:0]  d_mask;
  logic [ADDR_W-1:0]  d_addr, d_step;
  logic [BURST_W-1:0] d_burst, d_bnum;
  logic [1:0]         d_src;
  logic [31:0]        pb, pw;
  logic               idle_d;
  logic               unused_ok;

  assign ins_f = '{tgt: ins[63:60], ch: ins[59:58], str: ins[57],
                   buf_id: ins[56:52], dp: ins[48], row: ins[47:44],
                   pix: ins[43:40], size: ins[39:32], addr: ins[31:0]};
  assign unused_ok = ^ins[51:49];

  if (INS_W > 64) begin : g_hi
    logic unused_hi;
    assign unused_hi = ^ins[INS_W-1:64];
  end

  assign empty     = (cnt_q == '0);
  assign full      = (cnt_q == Q_FULL);
  assign ins_ready = !full;
  assign wr_en     = ins_valid && !full;
  assign hd        = mem_q[rp_q];
  assign hd_tgt    = TGT_NUM'(hd.tgt);

  // Head decode and issue decision, all from registered state
  always_comb begin
    hd_nop   = (hd.tgt == 4'h0) && !hd.str && (hd.buf_id == 5'h00);
    ch_ok    = {1'b0, hd.ch} < CH_LIM;
    tgt_free = ((hd_tgt & busy_tgt_q) == '0);
    ch_busy  = 1'b0;
    ch_oh    = '0;
    for (int c = 0; c < DDR_CH; c++) begin
      if (hd.ch == 2'(c)) begin
        ch_busy  = busy_ch_q[c];
        ch_oh[c] = 1'b1;
      end
    end
    pop   = 1'b0;
    issue = 1'b0;
    bad   = 1'b0;
    if (!empty) begin
      if (hd_nop) begin
        pop = 1'b1;
      end else if (!ch_ok) begin
        pop = 1'b1;
        bad = 1'b1;
      end else if (tgt_free && !ch_busy) begin
        pop   = 1'b1;
        issue = 1'b1;
      end
    end
  end

  always_comb begin
    d_mask = '0;
    unique case (1'b1)
      (hd.buf_id == 5'h1F):
        d_mask = '1;
      (hd.buf_id != 5'h1F) && layer_type[0]:
        d_mask = PE_ONE << hd.buf_id;
      (hd.buf_id != 5'h1F) && !layer_type[0]:
        d_mask = PE_NIB << {hd.buf_id, 2'b00};
    endcase
  end

  always_comb begin
    pb      = 32'(hd.pix) * 32'(in_ch_seg);
    pw      = 32'(hd.pix) * 32'(image_width);
    d_addr  = ADDR_W'(hd.addr);
    d_burst = hd.str ? BURST_W'(pb << 5) : BURST_W'(hd.size);
    d_step  = hd.str ? ADDR_W'(pw << 5) : '0;
    d_bnum  = hd.str ? BURST_W'(hd.row) : BURST_W'(1);
    d_src   = 2'b00;
    for (int t = TGT_NUM-1; t >= 0; t--) begin
      if (hd_tgt[t]) d_src = 2'(t);
    end
  end

  // Set on issue wins over a done for a bit that was not busy anyway
  always_comb begin
    cnt_d      = cnt_q + (AW+1)'(wr_en) - (AW+1)'(pop);
    busy_tgt_d = (busy_tgt_q & ~tgt_done) | (issue ? hd_tgt : '0);
    busy_ch_d  = (busy_ch_q & ~ddr_done) | (issue ? ch_oh : '0);
    idle_d     = (cnt_d == '0) && (busy_tgt_d == '0) && (busy_ch_d == '0);
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wp_q] <= ins_f;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q        <= '0;
      rp_q        <= '0;
      cnt_q       <= '0;
      busy_tgt_q  <= '0;
      busy_ch_q   <= '0;
      tgt_start_q <= '0;
      ddr_start_q <= '0;
      mode_q      <= '0;
      size_q      <= '0;
      row_q       <= '0;
      pix_q       <= '0;
      dp_q        <= 1'b0;
      mask_q      <= '0;
      idle_q      <= 1'b1;
      err_q       <= 1'b0;
      for (int c = 0; c < DDR_CH; c++) begin
        st_addr_q[c] <= '0;
        burst_q[c]   <= '0;
        step_q[c]    <= '0;
        bnum_q[c]    <= '0;
        src_q[c]     <= '0;
      end
    end else begin
      if (wr_en) wp_q <= wp_q + AW'(1);
      if (pop)   rp_q <= rp_q + AW'(1);
      cnt_q       <= cnt_d;
      busy_tgt_q  <= busy_tgt_d;
      busy_ch_q   <= busy_ch_d;
      idle_q      <= idle_d;
      tgt_start_q <= issue ? hd_tgt : '0;
      ddr_start_q <= issue ? ch_oh : '0;
      if (bad) err_q <= 1'b1;
      if (issue) begin
        mode_q <= layer_type;
        size_q <= hd.size;
        row_q  <= hd.row;
        pix_q  <= hd.pix;
        dp_q   <= hd.dp;
        mask_q <= d_mask;
      end
      for (int c = 0; c < DDR_CH; c++) begin
        if (issue && ch_oh[c]) begin
          st_addr_q[c] <= d_addr;
          burst_q[c]   <= d_burst;
          step_q[c]    <= d_step;
          bnum_q[c]    <= d_bnum;
          src_q[c]     <= d_src;
        end
      end
    end
  end

  assign tgt_start    = tgt_start_q;
  assign ddr_start    = ddr_start_q;
  assign conf_mode    = mode_q;
  assign conf_size    = size_q;
  assign conf_row_num = row_q;
  assign conf_pix_num = pix_q;
  assign conf_depool  = dp_q;
  assign conf_mask    = mask_q;
  assign idle         = idle_q;
  assign err_ch       = err_q;

  for (genvar c = 0; c < DDR_CH; c++) begin : g_out
    assign ddr_st_addr[c*ADDR_W +: ADDR_W]     = st_addr_q[c];
    assign ddr_burst[c*BURST_W +: BURST_W]     = burst_q[c];
    assign ddr_step[c*ADDR_W +: ADDR_W]        = step_q[c];
    assign ddr_burst_num[c*BURST_W +: BURST_W] = bnum_q[c];
    assign ddr_src_sel[c*2 +: 2]               = src_q[c];
  end

endmodule
